// File: rtl/spi_frame_ctrl.sv
// Frame controller for an SPI slave: decodes the command byte, then streams register writes or prefetched reads.
// Optional build macro SPI_FRAME_CHECKSUM_EN: in a write frame, tx_byte carries the running XOR of accepted payload bytes.
module spi_frame_ctrl #(
  parameter int         ADDR_W      = 7,
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_we,
  output logic [7:0]        reg_wdata,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              frame_done,
  output logic              len_err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ_REQ, READ_WAIT, READ} state_t;

  typedef struct packed {
    logic [7:0]        tx_byte;
    logic              tx_load;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [7:0]        wdata;
    logic              re;
    logic              done;
    logic              len_err;
    logic [CNT_W-1:0]  cnt;
  } ctrl_t;

  state_t            state, state_nxt;
  ctrl_t             q, d;
  logic              ssel_q;
  logic              cnt_ok;
  logic [ADDR_W-1:0] wr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ssel_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ssel_q <= ssel_active;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      q.tx_byte <= STATUS_BYTE;
    end else begin
      q <= d;
    end
  end

  always_comb begin
    state_nxt = state;
    d         = q;
    d.tx_load = 1'b0;
    d.we      = 1'b0;
    d.re      = 1'b0;
    d.done    = 1'b0;
    // Address advances the cycle after a write strobe, so a strobe always sees its own address.
    wr_addr   = q.we ? q.addr + 1'b1 : q.addr;
    cnt_ok    = q.cnt < CNT_W'(MAX_LEN);

    if (state != IDLE && !ssel_active) begin
      state_nxt = IDLE;
      d.done    = (state != CMD);
      d.tx_byte = STATUS_BYTE;
      d.addr    = (state == WRITE) ? wr_addr : q.addr;
    end else begin
      case (state)
        IDLE: begin
          if (ssel_active && !ssel_q) begin
            state_nxt = CMD;
            d.len_err = 1'b0;
            d.cnt     = '0;
            d.tx_byte = STATUS_BYTE;
            d.tx_load = 1'b1;
          end
        end
        CMD: begin
          if (rx_valid) begin
            d.addr = rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) begin
              state_nxt = READ_REQ;
              d.re      = 1'b1;
            end else begin
              state_nxt = WRITE;
              d.tx_byte = 8'h00;
            end
          end
        end
        WRITE: begin
          d.addr = wr_addr;
          if (rx_valid) begin
            if (cnt_ok) begin
              d.we    = 1'b1;
              d.wdata = rx_byte;
              d.cnt   = q.cnt + 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
              d.tx_byte = q.tx_byte ^ rx_byte;
              d.tx_load = 1'b1;
`endif
            end else begin
              d.len_err = 1'b1;
            end
          end
        end
        READ_REQ: state_nxt = READ_WAIT;
        READ_WAIT: begin
          state_nxt = READ;
          d.tx_byte = reg_rdata;
          d.tx_load = 1'b1;
          d.addr    = q.addr + 1'b1;
        end
        READ: begin
          if (rx_valid) begin
            if (cnt_ok) begin
              state_nxt = READ_REQ;
              d.re      = 1'b1;
              d.cnt     = q.cnt + 1'b1;
            end else begin
              d.tx_byte = 8'h00;
              d.tx_load = 1'b1;
              d.len_err = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign tx_byte    = q.tx_byte;
  assign tx_load    = q.tx_load;
  assign reg_addr   = q.addr;
  assign reg_we     = q.we;
  assign reg_wdata  = q.wdata;
  assign reg_re     = q.re;
  assign frame_done = q.done;
  assign len_err    = q.len_err;

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Frame-level controller sequencing the SPI slave byte datapath. Consumes the slave's received-byte strobe and data, decodes a command byte, then issues register-bus writes or prefetches register-bus reads to supply the slave's next transmit byte. Sits between the SPI slave shift logic and a synchronous register bank; frames are delimited by slave select.

Parameters:
ADDR_W, 7, register address width; command byte carries address in bits [ADDR_W-1:0], ADDR_W ≤ 7.
MAX_LEN, 16, maximum payload bytes per frame; excess bytes are ignored and flagged.
STATUS_BYTE, 8'hA5, byte presented for transmit while the command byte is shifting in.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ssel_active  in  1  synchronized slave-select, high during a frame
rx_valid  in  1  one-cycle pulse: a full byte was received
rx_byte  in  8  received byte, valid with rx_valid
tx_byte  out  8  byte the slave shifts out next
tx_load  out  1  one-cycle pulse: tx_byte updated
reg_addr  out  ADDR_W  register bus address
reg_we  out  1  one-cycle write strobe
reg_wdata  out  8  write data
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
frame_done  out  1  one-cycle pulse at end of a frame with ≥1 byte
len_err  out  1  sticky: a frame exceeded MAX_LEN; cleared at next frame start

Behaviour:
- Reset: state IDLE; tx_byte=STATUS_BYTE, tx_load=0, reg_addr=0, reg_we=0, reg_wdata=0, reg_re=0, frame_done=0, len_err=0, byte counter=0.
- States: IDLE, CMD, WRITE, READ_REQ, READ_WAIT, READ.
- IDLE: ssel_active rising → CMD; clear len_err, counter=0; tx_byte=STATUS_BYTE, tx_load pulse.
- CMD: rx_valid → latch reg_addr=rx_byte[ADDR_W-1:0]. rx_byte[7]=1 → READ_REQ; 0 → WRITE.
- WRITE: each rx_valid with counter<MAX_LEN → next cycle reg_we=1, reg_wdata=rx_byte, current address; address then increments. counter≥MAX_LEN → no strobe, len_err=1. tx_byte=8'h00 (see optional feature).
- READ_REQ: reg_re=1 for one cycle at reg_addr → READ_WAIT.
- READ_WAIT: capture reg_rdata into tx_byte, tx_load pulse; address increments → READ.
- READ: each rx_valid (dummy byte from master) with counter<MAX_LEN → READ_REQ. Beyond MAX_LEN → tx_byte=8'h00 with tx_load, len_err=1, stay in READ.
- Latency: rx_valid to reg_we = 1 cycle; rx_valid to tx_load in read = 3 cycles.
- Address wraps modulo 2^ADDR_W (e.g. 7'h7F → 7'h00), no error.
- Counter counts payload bytes only (command byte excluded); saturates at MAX_LEN.
- ssel_active low in any non-IDLE state → IDLE next cycle; pending read/write strobes for that cycle are suppressed; frame_done pulses if the command byte was received; tx_byte reset to STATUS_BYTE.
- rx_valid while ssel_active low: ignored.
- rx_valid coinciding with ssel_active falling: byte ignored, frame terminates.
- reg_we and reg_re never assert in the same cycle.

Optional Feature:
SPI_FRAME_CHECKSUM_EN: when defined, in WRITE, tx_byte holds the running XOR of all accepted payload bytes of the frame (initial 8'h00), updated with a tx_load pulse 1 cycle after each accepted rx_valid. The master reads the checksum of bytes 0..n-1 while sending byte n. When not defined, tx_byte is constant 8'h00 in WRITE and no tx_load occurs there.

Test Plan:
- Reset mid-frame (in WRITE) → all outputs at reset values immediately; after release, a new frame starts cleanly in CMD.
- Write frame: cmd 8'h05, data 8'h11, 8'h22 → reg_we at addr 5 with 8'h11, then addr 6 with 8'h22, each 1 cycle after rx_valid; frame_done on ssel drop; len_err=0.
- Read frame: cmd 8'h83, two dummy bytes, reg model returns addr → tx_byte 8'h03, then 8'h04, then 8'h05, each with tx_load 3 cycles after the triggering rx_valid.
- Wrap and length: ADDR_W=7, cmd 8'h7F, MAX_LEN+2 write bytes → writes at 7F, 00, 01…; exactly MAX_LEN reg_we; len_err=1; len_err clears at next ssel rise.
- Abort: ssel drops after cmd byte only → no reg_we/reg_re, frame_done=1, tx_byte=8'hA5; ssel drop before any byte → frame_done stays 0.
- With SPI_FRAME_CHECKSUM_EN: write 8'h0F, 8'hF0, 8'h3C → tx_byte sequence 8'h0F, 8'hFF, 8'hC3.
